pwm_fade_ctrl: RTL

Duty-cycle sequencer for the 8-bit PWM generator. It accepts fade commands (target duty, step period) over a valid/ready handshake. It ramps its duty output one LSB at a time toward the target and signals completion with a one-cycle pulse. `duty_out` connects directly to the PWM generator's 8-bit duty input; both blocks share one clock.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_fade_ctrl_tick.sv | 31 +++
 rtl/pwm_fade_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM fade controller
package pwm_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fade_state_t;

`ifdef PWM_FADE_GAMMA_EN
    // Square-law perceptual correction: (d*d + 255) >> 8 keeps 0->0 and 255->255.
    function automatic logic [DUTY_W-1:0] gamma_sq(input logic [DUTY_W-1:0] d);
        logic [2*DUTY_W-1:0] w_sq;
        w_sq = ({{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d}) + 16'd255;
        return w_sq[2*DUTY_W-1:DUTY_W];
    endfunction
`endif

endpackage

// File: rtl/pwm_fade_ctrl_tick.sv
// rtl/pwm_fade_ctrl_tick.sv - step-period counter producing the 1-LSB step strobe
module fade_tick #(
    parameter int STEP_DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [STEP_DIV_W-1:0] i_period_m1,
    output logic                  o_step
);

    logic [STEP_DIV_W-1:0] r_cnt;
    logic                  w_hit;

    // The counter never passes period-1, so it cannot overflow.
    assign w_hit  = (r_cnt == i_period_m1);
    assign o_step = i_en && w_hit;

    // Count enabled cycles; wrap to zero on the step strobe or an explicit clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_step) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + STEP_DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - duty-cycle fade sequencer for the 8-bit PWM (optional PWM_FADE_GAMMA_EN)
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int STEP_DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DUTY_W-1:0]     cmd_target,
    input  logic [STEP_DIV_W-1:0] cmd_period,
    input  logic                  abort,
    output logic [DUTY_W-1:0]     duty_out,
    output logic                  busy,
    output logic                  done
);

    fade_state_t           r_state;
    fade_state_t           w_state_nxt;
    logic [DUTY_W-1:0]     r_duty_q;
    logic [DUTY_W-1:0]     r_target;
    logic [STEP_DIV_W-1:0] r_period_m1;
    logic [STEP_DIV_W-1:0] w_period_m1_in;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_accept;
    logic                  w_tick_en;
    logic                  w_step;
    logic                  w_at_target;
    logic                  w_step_up;

    assign w_at_target    = (r_duty_q == r_target);
    assign w_step_up      = (r_target > r_duty_q);
    // A period of 0 behaves like 1, so the stored compare value is max(P,1)-1.
    assign w_period_m1_in = (cmd_period == '0) ? '0 : (cmd_period - STEP_DIV_W'(1));

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state == RAMP);
    assign done      = r_done;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle controls; abort beats completion, completion beats stepping.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_tick_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_at_target) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_tick_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    fade_tick #(
        .STEP_DIV_W (STEP_DIV_W)
    ) u_fade_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_accept),
        .i_en        (w_tick_en),
        .i_period_m1 (r_period_m1),
        .o_step      (w_step)
    );

    // One-cycle completion pulse, registered so it appears alongside cmd_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    // Command latch on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_target    <= '0;
            r_period_m1 <= '0;
        end else if (w_accept) begin
            r_target    <= cmd_target;
            r_period_m1 <= w_period_m1_in;
        end
    end

    // Linear duty moves one LSB toward the target per step; steps only occur
    // while duty differs from target, so it cannot overshoot or wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_duty_q <= '0;
        end else if (w_step) begin
            if (w_step_up) begin
                if (r_duty_q != DUTY_MAX) begin
                    r_duty_q <= r_duty_q + 8'd1;
                end
            end else begin
                if (r_duty_q != '0) begin
                    r_duty_q <= r_duty_q - 8'd1;
                end
            end
        end
    end

`ifdef PWM_FADE_GAMMA_EN
    assign duty_out = gamma_sq(r_duty_q);
`else
    assign duty_out = r_duty_q;
`endif

endmodule
